// File: rtl/hu_audiodec_dma_rd_arbiter_if.sv
// Bundle of the two requester ports and the ESP DMA read ctrl/chnl port.
// master: arbiter side. slave: requesters + DMA engine side.
interface hu_audiodec_dma_rd_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 32
);
  logic              rq0_ctrl_valid;
  logic              rq0_ctrl_ready;
  logic [LEN_W-1:0]  rq0_ctrl_index;
  logic [LEN_W-1:0]  rq0_ctrl_length;
  logic [2:0]        rq0_ctrl_size;
  logic              rq0_chnl_valid;
  logic              rq0_chnl_ready;

  logic              rq1_ctrl_valid;
  logic              rq1_ctrl_ready;
  logic [LEN_W-1:0]  rq1_ctrl_index;
  logic [LEN_W-1:0]  rq1_ctrl_length;
  logic [2:0]        rq1_ctrl_size;
  logic              rq1_chnl_valid;
  logic              rq1_chnl_ready;

  logic [DATA_W-1:0] rq_chnl_data;

  logic              dma_read_ctrl_valid;
  logic              dma_read_ctrl_ready;
  logic [LEN_W-1:0]  dma_read_ctrl_data_index;
  logic [LEN_W-1:0]  dma_read_ctrl_data_length;
  logic [2:0]        dma_read_ctrl_data_size;
  logic              dma_read_chnl_valid;
  logic              dma_read_chnl_ready;
  logic [DATA_W-1:0] dma_read_chnl_data;

  logic              grant;
  logic              busy;

  modport master (
    input  rq0_ctrl_valid, rq0_ctrl_index, rq0_ctrl_length, rq0_ctrl_size, rq0_chnl_ready,
    input  rq1_ctrl_valid, rq1_ctrl_index, rq1_ctrl_length, rq1_ctrl_size, rq1_chnl_ready,
    output rq0_ctrl_ready, rq0_chnl_valid, rq1_ctrl_ready, rq1_chnl_valid, rq_chnl_data,
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    output dma_read_ctrl_data_size, dma_read_chnl_ready,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
    output grant, busy
  );

  modport slave (
    output rq0_ctrl_valid, rq0_ctrl_index, rq0_ctrl_length, rq0_ctrl_size, rq0_chnl_ready,
    output rq1_ctrl_valid, rq1_ctrl_index, rq1_ctrl_length, rq1_ctrl_size, rq1_chnl_ready,
    input  rq0_ctrl_ready, rq0_chnl_valid, rq1_ctrl_ready, rq1_chnl_valid, rq_chnl_data,
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    input  dma_read_ctrl_data_size, dma_read_chnl_ready,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
    input  grant, busy
  );
endinterface

// File: rtl/hu_audiodec_dma_rd_arbiter.sv
// Two-requester arbiter for the audio decoder's DMA read path; beats pass through unregistered.
// Define HU_DMA_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module hu_audiodec_dma_rd_arbiter #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 32
) (
  input  logic clk,
  input  logic rst,
  hu_audiodec_dma_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;

  state_t            state, state_nxt;
  logic              grant_q;
  logic [LEN_W-1:0]  index_q, length_q, cnt_q;
  logic [2:0]        size_q;
  logic              any_req, win, sel_ready, ctrl_hs, beat_hs;
  logic [DATA_W-1:0] data_p0;

  assign any_req = bus.rq0_ctrl_valid | bus.rq1_ctrl_valid;

  always_comb begin
    win = bus.rq1_ctrl_valid;
    if (bus.rq0_ctrl_valid && bus.rq1_ctrl_valid) begin
`ifdef HU_DMA_RD_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~grant_q;
`endif
    end
  end

  assign sel_ready = grant_q ? bus.rq1_chnl_ready : bus.rq0_chnl_ready;
  assign ctrl_hs   = (state == CTRL) && bus.dma_read_ctrl_ready;
  assign beat_hs   = (state == DATA) && bus.dma_read_chnl_valid && sel_ready;

  always_comb begin
    state_nxt               = state;
    bus.rq0_ctrl_ready      = 1'b0;
    bus.rq1_ctrl_ready      = 1'b0;
    bus.dma_read_ctrl_valid = 1'b0;
    bus.dma_read_chnl_ready = 1'b0;
    bus.rq0_chnl_valid      = 1'b0;
    bus.rq1_chnl_valid      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = CTRL;
          if (win) bus.rq1_ctrl_ready = 1'b1;
          else     bus.rq0_ctrl_ready = 1'b1;
        end
      end
      CTRL: begin
        bus.dma_read_ctrl_valid = 1'b1;
        if (bus.dma_read_ctrl_ready)
          state_nxt = (length_q == '0) ? IDLE : DATA;
      end
      DATA: begin
        bus.dma_read_chnl_ready = sel_ready;
        if (grant_q) bus.rq1_chnl_valid = bus.dma_read_chnl_valid;
        else         bus.rq0_chnl_valid = bus.dma_read_chnl_valid;
        if (beat_hs && cnt_q == LEN_W'(1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture at grant, beat counter loaded on the ctrl handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant_q  <= 1'b1;
      index_q  <= '0;
      length_q <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant_q  <= win;
        index_q  <= win ? bus.rq1_ctrl_index  : bus.rq0_ctrl_index;
        length_q <= win ? bus.rq1_ctrl_length : bus.rq0_ctrl_length;
        size_q   <= win ? bus.rq1_ctrl_size   : bus.rq0_ctrl_size;
      end
      if (ctrl_hs)
        cnt_q <= length_q;
      else if (beat_hs && cnt_q != '0)
        cnt_q <= cnt_q - LEN_W'(1);
    end
  end

  assign data_p0                       = bus.dma_read_chnl_data;
  assign bus.rq_chnl_data              = data_p0;
  assign bus.dma_read_ctrl_data_index  = index_q;
  assign bus.dma_read_ctrl_data_length = length_q;
  assign bus.dma_read_ctrl_data_size   = size_q;
  assign bus.grant                     = grant_q;
  assign bus.busy                      = (state != IDLE);

endmodule

// File: tb/tb_hu_audiodec_dma_rd_arbiter.sv
// Directed bench for hu_audiodec_dma_rd_arbiter with a beat scoreboard.
module tb_hu_audiodec_dma_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hu_audiodec_dma_rd_arbiter_if bus ();

  hu_audiodec_dma_rd_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef HU_DMA_RD_ARB_FIXED_PRIO_EN
  localparam bit TIE2_WIN = 1'b0;
`else
  localparam bit TIE2_WIN = 1'b1;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rq(input bit r, input bit v, input logic [31:0] idx,
                          input logic [31:0] len, input logic [2:0] sz);
    if (!r) begin
      bus.rq0_ctrl_valid = v; bus.rq0_ctrl_index = idx;
      bus.rq0_ctrl_length = len; bus.rq0_ctrl_size = sz;
    end else begin
      bus.rq1_ctrl_valid = v; bus.rq1_ctrl_index = idx;
      bus.rq1_ctrl_length = len; bus.rq1_ctrl_size = sz;
    end
  endtask

  function automatic logic ctrl_rdy(input bit r);
    return r ? bus.rq1_ctrl_ready : bus.rq0_ctrl_ready;
  endfunction

  function automatic logic chnl_vld(input bit r);
    return r ? bus.rq1_chnl_valid : bus.rq0_chnl_valid;
  endfunction

  task automatic set_chnl_rdy(input bit r, input logic v);
    if (r) bus.rq1_chnl_ready = v;
    else   bus.rq0_chnl_ready = v;
  endtask

  task automatic accept(input bit r, input logic [31:0] idx, input logic [31:0] len,
                        input logic [2:0] sz);
    int n = 0;
    drive_rq(r, 1'b1, idx, len, sz);
    #1;
    while (!ctrl_rdy(r) && n < 50) begin
      tick; #1; n++;
    end
    check("accept_ready", ctrl_rdy(r), 1);
    tick;
    drive_rq(r, 1'b0, idx, len, sz);
    #1;
    check("ctrl_valid", bus.dma_read_ctrl_valid, 1);
    check("ctrl_index", bus.dma_read_ctrl_data_index, idx);
    check("ctrl_length", bus.dma_read_ctrl_data_length, len);
    check("ctrl_size", bus.dma_read_ctrl_data_size, sz);
    check("grant", bus.grant, r);
    check("busy_ctrl", bus.busy, 1);
  endtask

  task automatic ctrl_hs;
    bus.dma_read_ctrl_ready = 1'b1;
    #1;
    tick;
    bus.dma_read_ctrl_ready = 1'b0;
  endtask

  task automatic serve(input bit r, input int n, input logic [63:0] base, input bit toggle);
    int c = 0;
    int hs = 0;
    int nxt = 0;
    logic rdy;
    logic [63:0] exp_d;
    for (int k = 0; k < n; k++) sb.push_back(base + 64'(k));
    while (sb.size() > 0 && c < 100) begin
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      bus.dma_read_chnl_valid = 1'b1;
      bus.dma_read_chnl_data  = base + 64'(nxt);
      set_chnl_rdy(r, rdy);
      #1;
      if (c == 0) check("first_beat_valid", chnl_vld(r), 1);
      check("chnl_ready_mirror", bus.dma_read_chnl_ready, rdy);
      check("other_chnl_valid", chnl_vld(!r), 0);
      if (bus.dma_read_chnl_ready && chnl_vld(r)) begin
        exp_d = sb.pop_front();
        check("beat_data", bus.rq_chnl_data, exp_d);
        hs++;
      end
      if (rdy) nxt++;
      tick;
      c++;
    end
    bus.dma_read_chnl_valid = 1'b0;
    set_chnl_rdy(r, 1'b0);
    #1;
    check("beat_count", 64'(hs), 64'(n));
    check("sb_empty", 64'(sb.size()), 0);
    check("busy_after", bus.busy, 0);
    sb.delete();
  endtask

  task automatic check_reset_vals;
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant, 1);
    check("rst_ctrl_valid", bus.dma_read_ctrl_valid, 0);
    check("rst_ctrl_index", bus.dma_read_ctrl_data_index, 0);
    check("rst_ctrl_length", bus.dma_read_ctrl_data_length, 0);
    check("rst_ctrl_size", bus.dma_read_ctrl_data_size, 0);
    check("rst_chnl_ready", bus.dma_read_chnl_ready, 0);
    check("rst_rq0_chnl_valid", bus.rq0_chnl_valid, 0);
    check("rst_rq1_chnl_valid", bus.rq1_chnl_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_rq(0, 1'b0, 0, 0, 0);
    drive_rq(1, 1'b0, 0, 0, 0);
    bus.rq0_chnl_ready = 1'b0;
    bus.rq1_chnl_ready = 1'b0;
    bus.dma_read_ctrl_ready = 1'b0;
    bus.dma_read_chnl_valid = 1'b0;
    bus.dma_read_chnl_data  = '0;
    repeat (3) tick;
    check_reset_vals();
    rst = 1'b1;
    tick;

    // Tie right after reset: requester 0 wins
    drive_rq(0, 1'b1, 32'h10, 2, 3'd1);
    drive_rq(1, 1'b1, 32'h20, 2, 3'd2);
    #1;
    check("tie1_rq0_ready", bus.rq0_ctrl_ready, 1);
    check("tie1_rq1_ready", bus.rq1_ctrl_ready, 0);
    accept(0, 32'h10, 2, 3'd1);
    check("tie1_loser_no_ready", bus.rq1_ctrl_ready, 0);
    ctrl_hs();
    serve(0, 2, 64'hB0, 1'b0);

    // Second tie: rotates to rq1 unless fixed priority
    drive_rq(0, 1'b1, 32'h10, 2, 3'd1);
    #1;
    check("tie2_rq0_ready", bus.rq0_ctrl_ready, !TIE2_WIN);
    check("tie2_rq1_ready", bus.rq1_ctrl_ready, TIE2_WIN);
    accept(TIE2_WIN, TIE2_WIN ? 32'h20 : 32'h10, 2, TIE2_WIN ? 3'd2 : 3'd1);
    ctrl_hs();
    serve(TIE2_WIN, 2, 64'hC0, 1'b0);
    accept(!TIE2_WIN, !TIE2_WIN ? 32'h20 : 32'h10, 2, !TIE2_WIN ? 3'd2 : 3'd1);
    ctrl_hs();
    serve(!TIE2_WIN, 2, 64'hD0, 1'b0);

    // Single request
    accept(0, 32'h100, 4, 3'd3);
    ctrl_hs();
    serve(0, 4, 64'hA0, 1'b0);

    // Ctrl stall with a competing request and stray beats
    accept(0, 32'h200, 1, 3'd3);
    drive_rq(1, 1'b1, 32'h300, 3, 3'd2);
    bus.dma_read_chnl_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_ctrl_valid", bus.dma_read_ctrl_valid, 1);
      check("stall_index", bus.dma_read_ctrl_data_index, 32'h200);
      check("stall_length", bus.dma_read_ctrl_data_length, 1);
      check("stall_rq1_ready", bus.rq1_ctrl_ready, 0);
      check("stall_chnl_ready", bus.dma_read_chnl_ready, 0);
      tick; #1;
    end
    bus.dma_read_chnl_valid = 1'b0;
    ctrl_hs();
    serve(0, 1, 64'hE0, 1'b0);

    // Backpressure on rq1
    accept(1, 32'h300, 3, 3'd2);
    ctrl_hs();
    serve(1, 3, 64'hF0, 1'b1);

    // Zero length with rq1 pending
    accept(0, 32'h400, 0, 3'd1);
    drive_rq(1, 1'b1, 32'h500, 8, 3'd3);
    bus.dma_read_chnl_valid = 1'b1;
    bus.dma_read_ctrl_ready = 1'b1;
    #1;
    check("zl_chnl_ready", bus.dma_read_chnl_ready, 0);
    check("zl_rq1_ready_ctrl", bus.rq1_ctrl_ready, 0);
    tick;
    bus.dma_read_ctrl_ready = 1'b0;
    #1;
    check("zl_busy", bus.busy, 0);
    check("zl_rq1_ready_next", bus.rq1_ctrl_ready, 1);
    check("zl_chnl_ready_idle", bus.dma_read_chnl_ready, 0);
    bus.dma_read_chnl_valid = 1'b0;
    accept(1, 32'h500, 8, 3'd3);
    ctrl_hs();

    // Reset after 2 of 8 beats
    for (int k = 0; k < 2; k++) begin
      bus.dma_read_chnl_valid = 1'b1;
      bus.dma_read_chnl_data  = 64'h1000 + 64'(k);
      bus.rq1_chnl_ready      = 1'b1;
      #1;
      check("mid_rq1_valid", bus.rq1_chnl_valid, 1);
      check("mid_data", bus.rq_chnl_data, 64'h1000 + 64'(k));
      tick;
    end
    rst = 1'b0;
    tick;
    check_reset_vals();
    rst = 1'b1;
    bus.dma_read_chnl_valid = 1'b0;
    bus.rq1_chnl_ready      = 1'b0;
    tick;
    accept(1, 32'h600, 2, 3'd1);
    ctrl_hs();
    serve(1, 2, 64'h77, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
